// File: rtl/perf_counter_bank.sv
// Event-counter bank with cycle counter; freezes on halt and streams a snapshot out the dump port.
// Latency: live read is registered (1 cycle); first dump beat is valid the cycle after halt.
// Backpressure: dump beats hold stable while dump_ready is low; no bubbles between accepted beats.
module perf_counter_bank #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    localparam int CH_W    = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] events,   // "event" is a reserved word in SystemVerilog
    input  logic              halt,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [CH_W-1:0]   dump_ch,
    output logic [CNT_W-1:0]  dump_data,
    output logic              dump_ovf,
    output logic              dump_last,
    output logic              done,
    output logic [NUM_CH:0]   ovf
);

    typedef enum logic [1:0] {COUNT, DUMP, DONE} stateT;

    stateT                        state, stateNext;
    logic [NUM_CH:0][CNT_W-1:0]   cnt, cntNext;
    logic [NUM_CH:0]              ovfReg, ovfNext;
    logic [NUM_CH:0]              incVec;
    logic [CH_W-1:0]              dumpCh, dumpChNext;
    logic [CNT_W-1:0]             rdMux, dumpMux;
    logic                         dumpOvfBit;
    logic                         countEn;

    // Slot NUM_CH is the cycle counter, which ticks every enabled cycle.
    assign incVec  = {1'b1, events};
    assign countEn = (state == COUNT) && en && !clr;

    always_comb begin
        cntNext = cnt;
        ovfNext = ovfReg;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (incVec[i]) begin
                if (&cnt[i]) begin
                    ovfNext[i] = 1'b1;
                    if (SATURATE != 0) cntNext[i] = cnt[i];
                    else               cntNext[i] = '0;
                end else begin
                    cntNext[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Compare-based select keeps out-of-range indices reading as zero.
    always_comb begin
        rdMux      = '0;
        dumpMux    = '0;
        dumpOvfBit = 1'b0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_sel == CH_W'(i)) rdMux = cnt[i];
            if (dumpCh == CH_W'(i)) begin
                dumpMux    = cnt[i];
                dumpOvfBit = ovfReg[i];
            end
        end
    end

    always_comb begin
        stateNext  = state;
        dumpChNext = dumpCh;
        if (clr) begin
            stateNext  = COUNT;
            dumpChNext = '0;
        end else begin
            case (state)
                COUNT: begin
                    if (en && halt) begin
                        stateNext  = DUMP;
                        dumpChNext = '0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dumpCh == CH_W'(NUM_CH)) stateNext  = DONE;
                        else                         dumpChNext = dumpCh + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= COUNT;
            dumpCh <= '0;
        end else begin
            state  <= stateNext;
            dumpCh <= dumpChNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ovfReg  <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= rdMux;
            if (clr) begin
                cnt    <= '0;
                ovfReg <= '0;
            end else if (countEn) begin
                cnt    <= cntNext;
                ovfReg <= ovfNext;
            end
        end
    end

    assign dump_valid = (state == DUMP);
    assign dump_ch    = dumpCh;
    assign dump_data  = dump_valid ? dumpMux : '0;
    assign dump_ovf   = dump_valid & dumpOvfBit;
    assign dump_last  = dump_valid && (dumpCh == CH_W'(NUM_CH));
    assign done       = (state == DONE);
    assign ovf        = ovfReg;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised event-counter bank. It replaces the testbench-only cycle, instruction and cache hit/request counters with hardware counters.
- Sits beside the pipeline inside proc_hier. Takes one-bit event strobes, e.g. retire, ICacheReq/Hit, DCacheReq/Hit.
- On halt it freezes the counters and streams a snapshot of every counter over a valid/ready dump port.
- Also provides a registered random-access read port for live inspection.

Parameters:
- NUM_CH, 8: number of event counters.
- CNT_W, 32: width of each counter, including the cycle counter.
- SATURATE, 1: overflow mode. 1 = hold at max; 0 = wrap to zero.
- CH_W, $clog2(NUM_CH+1): index width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  counting enable.
- clr  in  1  synchronous clear of all counters and flags; returns the block to COUNT.
- event  in  NUM_CH  per-channel increment strobes.
- halt  in  1  processor halt strobe.
- rd_sel  in  CH_W  live-read channel select. Index NUM_CH selects the cycle counter.
- rd_data  out  CNT_W  registered live-read value.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat accepted.
- dump_ch  out  CH_W  channel index of the current beat.
- dump_data  out  CNT_W  counter value of the current beat.
- dump_ovf  out  1  sticky overflow flag of the current channel.
- dump_last  out  1  current beat is the final one (cycle counter).
- done  out  1  dump complete.
- ovf  out  NUM_CH+1  sticky overflow flags. Bit NUM_CH is the cycle counter.

Behaviour:
- Reset (rst_n low, asynchronous, effective without a clock edge):
  - all counters and ovf cleared to 0;
  - state = COUNT;
  - dump_valid, dump_ch, dump_data, dump_ovf, dump_last, done, rd_data all 0.
- States: COUNT, DUMP, DONE. The state register is private.
- COUNT, en=1:
  - cycle counter += 1;
  - counter[i] += event[i], for all i, every cycle.
- COUNT, en=0: counters hold; halt and event are ignored.
- Overflow: an increment applied to an all-ones counter sets ovf[i] (sticky). The counter then holds at all-ones if SATURATE=1, or wraps to 0 if SATURATE=0.
- halt=1 in COUNT with en=1:
  - that cycle's events and cycle tick are still counted;
  - state -> DUMP and counters freeze from the next cycle;
  - dump_valid rises in the cycle after halt is sampled, with dump_ch = 0.
- DUMP:
  - Beats run in order: channel 0 .. NUM_CH-1, then the cycle counter at index NUM_CH.
  - dump_data and dump_ovf reflect the frozen value of counter[dump_ch].
  - While dump_valid=1 and dump_ready=0, all dump_* outputs hold stable.
  - A handshake (valid & ready) advances dump_ch by one. There are no bubbles: the next beat is valid in the following cycle.
  - dump_last=1 only while dump_ch == NUM_CH.
  - The handshake on the last beat takes the state to DONE: dump_valid -> 0 and done -> 1 on the next cycle.
  - event, halt and en are ignored in DUMP and DONE.
- DONE: counters frozen; holds until clr or reset.
- clr (any state):
  - on the next edge: all counters and ovf = 0, state = COUNT, dump_valid = 0, done = 0, dump_ch = 0;
  - clr has priority over halt and event in the same cycle; nothing is counted that cycle.
- Live read:
  - rd_data <= value of the counter selected by rd_sel, as held before this edge's update;
  - one-cycle latency;
  - rd_sel > NUM_CH returns 0;
  - works in every state.
- Width rule: all counter arithmetic is CNT_W bits, unsigned. There is no carry between counters.

Test Plan:
- NUM_CH=4, CNT_W=8. Hold en=1 and assert event[0] for 10 cycles and event[2] for 3 of them; halt on the 10th cycle; dump_ready=1.
  -> Beats (ch,data) = (0,10) (1,0) (2,3) (3,0) (4,10), on 5 consecutive cycles; dump_last on ch4; done=1 one cycle later.
- CNT_W=8, event[1] held for 300 cycles:
  -> SATURATE=1: count=255, ovf[1]=1.
  -> SATURATE=0: count=44, ovf[1]=1.
  -> ovf[0]=0 in both cases.
- Dump with dump_ready toggling 0,1,0,1...
  -> dump_* stable across every ready=0 cycle; each channel delivered exactly once; 5 beats total; done only after the ch4 handshake.
- clr and halt asserted in the same cycle after 7 counted cycles.
  -> State COUNT, all counters 0, dump_valid stays 0; the next cycle's count is 1.
- rst_n driven low mid-DUMP, between clock edges.
  -> dump_valid and done go to 0 immediately; counters 0; after release, counting resumes from 0.
- en=0 for 5 cycles with event all-ones and halt=1, then rd_sel=2.
  -> No counter changes, no dump; rd_data equals the prior ch2 value one cycle after rd_sel is applied; rd_sel=7 returns 0.
